dmem_bus: RTL and testbench

DMEM_BUS -- requirements
Module: dmem_bus

---
 rtl/dmem_bus.sv | 190 +++++++++++++++++++
 tb/tb_dmem_bus.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus
// Description : Single-port data memory behind a valid/ready request and
//               response handshake. Supports byte, half and word loads and
//               stores with sign or zero extension on sub-word loads.
//               Misaligned or reserved-size requests are rejected with an
//               error response and leave memory untouched. Each legal access
//               spends a programmable number of wait cycles in BUSY.
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready  request handshake
//               req_write, req_size, req_unsigned, req_addr, req_wdata
//               resp_valid/resp_ready response handshake
//               resp_rdata, resp_err  (both 0 while resp_valid is 0)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus #(
  parameter int N           = 32,  // data width, fixed at 32 in this generation
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,  // power of two, 2..4096
  parameter int WAIT_CYCLES = 1    // 0..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [N-1:0]      req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N-1:0]      resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]       r_cnt;
  logic             r_write;
  logic             r_uns;
  logic             r_err;
  logic [1:0]       r_size;
  logic [1:0]       r_lane;
  logic [IDX_W-1:0] r_idx;
  logic [N-1:0]     r_wdata;
  logic [N-1:0]     r_rdata;

  logic [N-1:0]     mem [DEPTH];

  logic             w_req_err;
  logic             w_accept;
  logic             w_access;
  logic [N-1:0]     w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [N-1:0]     w_load;
  logic [3:0]       w_be;
  logic [N-1:0]     w_wdata;
  logic             w_unused;

  // Address bits above the word index are ignored, so addresses alias.
  assign w_unused = ^req_addr[ADDR_W-1:IDX_W+2];

  assign w_req_err = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Gating with rst_n keeps req_ready low for the whole reset interval.
  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_access  = (r_state == BUSY) && (r_cnt == 4'd0);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_req_err ? RESP : BUSY;
      BUSY: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter and result register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= C_WAIT;
      r_write <= req_write;
      r_uns   <= req_unsigned;
      r_err   <= w_req_err;
      r_size  <= req_size;
      r_lane  <= req_addr[1:0];
      r_idx   <= req_addr[IDX_W+1:2];
      r_wdata <= req_wdata;
      r_rdata <= '0;
    end else if (r_state == BUSY) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      else               r_rdata <= r_write ? '0 : w_load;
    end
  end

  // --------------------------------------------------------------------------
  // Load lane extraction and extension
  // --------------------------------------------------------------------------
  assign w_word = mem[r_idx];
  assign w_byte = w_word[{r_lane, 3'b000} +: 8];
  assign w_half = w_word[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_word;
    case (r_size)
      2'b00: w_load = r_uns ? {{(N-8){1'b0}}, w_byte}
                            : {{(N-8){w_byte[7]}}, w_byte};
      2'b01: w_load = r_uns ? {{(N-16){1'b0}}, w_half}
                            : {{(N-16){w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // --------------------------------------------------------------------------
  // Store lane enables; data is replicated so every enabled lane sees it
  // --------------------------------------------------------------------------
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_lane;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Memory is never reset; a reset during BUSY forces IDLE, so no write occurs.
  always_ff @(posedge clk) begin
    if (rst_n && w_access && r_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) mem[r_idx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs, forced to zero outside RESP
  // --------------------------------------------------------------------------
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
  assign resp_err   = resp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus
// Description : Self-checking bench for dmem_bus. A byte-array model of the
//               memory supplies expected load data, error flags and latency
//               for directed and randomized requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus;

  localparam int WAIT  = 1;
  localparam int DEPTH = 64;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [BYTES];

  dmem_bus #(
    .N(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] a);
    int unsigned p = a % BYTES;
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = {24'd0, ref_mem[p]};
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = {16'd0, ref_mem[p+1], ref_mem[p]};
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = {ref_mem[p+3], ref_mem[p+2], ref_mem[p+1], ref_mem[p]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
    int unsigned p = a % BYTES;
    int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) ref_mem[p+k] = wd[8*k +: 8];
  endtask

  // One complete transaction: issue, measure latency, check the response,
  // optionally stall the consumer, then complete the handshake.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] got);
    bit e;
    logic [31:0] exp;
    int edges;
    e   = is_err(sz, a);
    exp = (w || e) ? 32'd0 : model_load(sz, uns, a);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    edges = 1;
    while (!resp_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("latency", edges, e ? 32'd1 : 32'(WAIT + 2));
    check("resp_err", {31'd0, resp_err}, {31'd0, e});
    check("resp_rdata", resp_rdata, exp);
    check("no_overlap_ready", {31'd0, req_ready}, 32'd0);
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, exp);
      check("hold_err", {31'd0, resp_err}, {31'd0, e});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rdata", resp_rdata, 32'd0);
    check("post_err", {31'd0, resp_err}, 32'd0);
    check("post_ready", {31'd0, req_ready}, 32'd1);
    if (w && !e) model_store(sz, a, wd);
  endtask

  logic [31:0] got;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_ready", {31'd0, req_ready}, 32'd1);

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0, got);

    // Word store / load
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, 0, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, got);
    check("d_word_ffff", got, 32'hFFFF_FFFF);

    // Byte store and sign/zero extension
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0, 0, got);
    do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h80, 0, got);
    do_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 0, got);
    check("d_byte_signed", got, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h5, 32'h0, 0, got);
    check("d_byte_unsigned", got, 32'h0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0, got);
    check("d_word_after_byte", got, 32'h0000_8000);

    // Half store over an all-ones word
    do_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h1234, 0, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, got);
    check("d_word_after_half", got, 32'h1234_FFFF);
    do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 0, got);
    check("d_half_signed", got, 32'h0000_1234);

    // Error requests leave memory alone
    do_req(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 0, got);
    check("d_err_half_rdata", got, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'hDEAD_BEEF, 0, got);
    check("d_err_word_rdata", got, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 32'h4, 32'hDEAD_BEEF, 0, got);
    check("d_err_size_rdata", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0, got);
    check("d_mem_unchanged", got, 32'h0000_8000);

    // Address wrap-around
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hA5A5_A5A5, 0, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, got);
    check("d_wrap", got, 32'hA5A5_A5A5);

    // Consumer stall
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5, got);
    check("d_stall_data", got, 32'hA5A5_A5A5);

    // Reset during BUSY of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h5555_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("busy_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("busy_rst_ready", {31'd0, req_ready}, 32'd0);
    check("busy_rst_rdata", resp_rdata, 32'd0);
    check("busy_rst_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("busy_rst_ready_after", {31'd0, req_ready}, 32'd1);
    check("busy_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, got);
    check("busy_rst_old_data", got, {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)),
             $urandom, $urandom_range(0, 3), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
